mem_stage: RTL
==============

# mem_stage

Memory-access stage of the rv32i pipeline, between the EX/MEM and MEM/WB pipeline registers. Issues load/store requests to the data cache, generates byte masks and replicated store data, and aligns and sign/zero-extends load data. Produces the `mem_rdata` word captured by the MEM/WB register. Holds the pipeline with `mem_stall` until the cache responds, and holds the result until the pipeline advances.

## Interface
- No parameters; all datapaths are 32-bit `rv32i_word`.

- `clk`  in  1  clock; the block has one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `exmem_valid`  in  1  EX/MEM holds a real instruction (0 = bubble).
- `exmem_mem_read`  in  1  instruction is a load.
- `exmem_mem_write`  in  1  instruction is a store.
- `exmem_funct3`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `exmem_alu_out`  in  32  effective byte address.
- `exmem_rs2_out`  in  32  store source data.
- `pipeline_load`  in  1  global pipeline-register load (advance) this cycle.
- `data_read`  out  1  cache read request.
- `data_write`  out  1  cache write request.
- `data_mbe`  out  4  byte enables.
- `data_addr`  out  32  word-aligned address.
- `data_wdata`  out  32  store data.
- `data_resp`  in  1  cache completion, one-cycle pulse.
- `data_rdata`  in  32  cache read word, valid with `data_resp`.
- `mem_rdata`  out  32  aligned/extended load result.
- `mem_stall`  out  1  stage cannot complete this cycle.
- `mem_misaligned`  out  1  current access is misaligned and is suppressed.

## Operation
- `op` = `exmem_valid & (exmem_mem_read | exmem_mem_write) & !mem_misaligned`. If both read and write are set, the access is a read and the write is ignored.
- Misaligned conditions:
  - H/HU with `addr[0]=1`.
  - W with `addr[1:0]!=0`.
  - When misaligned: `mem_misaligned=1`, no request is issued, `mem_stall=0`, `mem_rdata=0`.
- `data_addr = {exmem_alu_out[31:2],2'b00}`; `off = exmem_alu_out[1:0]`.
- Store byte enables and data:
  - SB: `mbe=4'b0001<<off`, `wdata={4{rs2[7:0]}}`.
  - SH: `mbe=4'b0011<<off`, `wdata={2{rs2[15:0]}}`.
  - SW: `mbe=4'b1111`, `wdata=rs2`.
  - Loads: `mbe=4'b1111`.
- Load extraction from `rdata_q`:
  - B/BU: byte `off`, sign- or zero-extended.
  - H/HU: halfword `off[1]`, sign- or zero-extended.
  - W: whole word.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if `op` and `data_resp`, go to DONE. If `op` and no resp, go to BUSY.
  - BUSY: on `data_resp`, go to DONE.
  - DONE: on `pipeline_load`, go to IDLE; otherwise hold.
- `data_read`/`data_write` are asserted only while `op` and state is IDLE or BUSY. They are never asserted in DONE.
- `rdata_q` loads `data_rdata` on `data_resp` (loads only) and holds otherwise.
- `mem_stall = op & (state != DONE)`.
- `mem_rdata` = extracted load when state is DONE and the access is a load; 0 otherwise.
- EX/MEM inputs are stable while `mem_stall=1` or state is DONE, because EX/MEM does not load then. Extraction uses the live `funct3`/`off`.

## Timing
- Reset values: state=IDLE, `rdata_q=0`; outputs `data_read=0`, `data_write=0`, `mem_stall=0`, `mem_rdata=0`.
  - `data_mbe`, `data_addr`, `data_wdata`, and `mem_misaligned` are combinational from inputs.
- Request outputs are combinational from state and inputs; they are held high until the `data_resp` cycle inclusive.
- Latency: `data_resp` in cycle N gives `mem_stall=0` and valid `mem_rdata` in cycle N+1.
  - Minimum memory op is 2 cycles in the stage (resp in the first cycle).
  - A cycle with no memory op, a bubble, or a misaligned access completes in 1 cycle with no stall.
- DONE with `pipeline_load=0` (stall from another stage): hold DONE, hold `rdata_q`, issue no new request.
- DONE with `pipeline_load=1`: return to IDLE next cycle; the next instruction's request can start that cycle.
- `data_resp` while in IDLE without `op`, or while in DONE: ignored.
- `rst` mid-transaction: return to IDLE next cycle and drop the request. The cache transaction is abandoned; reset is used only at system reset.

## Test plan
- LW at `0x100`, `data_resp` after 3 cycles with `0xDEADBEEF`:
  - `data_read=1` and `data_addr=0x100` for 3 cycles.
  - Then `mem_stall=0` and `mem_rdata=0xDEADBEEF`.
- LB at `0x103` and LBU at `0x103`, rdata `0x80FF_0000`:
  - LB gives `mem_rdata=0xFFFFFF80`.
  - LBU gives `0x00000080`.
- SH at `0x202`, `rs2=0x1234ABCD`:
  - `data_write=1`, `data_addr=0x200`, `data_mbe=4'b1100`, `data_wdata=0xABCDABCD`.
- LW at `0x101`:
  - `mem_misaligned=1` and `mem_stall=0`.
  - `data_read=0` and `mem_rdata=0`.
- LHU at `0x302`, rdata `0xBEEF0000`; resp arrives, `pipeline_load` held 0 for 4 cycles:
  - Stays in DONE with `data_read=0` and `mem_rdata=0x0000BEEF` stable.
  - Returns to IDLE after `pipeline_load=1`.
- `rst` asserted while in BUSY:
  - Next cycle: `data_read=0`, `mem_stall` deasserted with `exmem_valid=0`, state IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: rv32i memory-access stage. Drives data-cache requests, builds
// store byte enables and replicated store data, and aligns/extends the load
// word into mem_rdata. Stalls the pipeline until the cache answers, then
// parks in DONE holding the result until the pipeline advances.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        exmem_valid,
  input  logic        exmem_mem_read,
  input  logic        exmem_mem_write,
  input  logic [2:0]  exmem_funct3,
  input  logic [31:0] exmem_alu_out,
  input  logic [31:0] exmem_rs2_out,
  input  logic        pipeline_load,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_mbe,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_resp,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_misaligned
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_rdataQ;

  logic [1:0]  w_off;
  logic        w_isByte;
  logic        w_isHalf;
  logic        w_isWord;
  logic        w_unsigned;
  logic        w_access;
  logic        w_isLoad;
  logic        w_isStore;
  logic        w_op;
  logic        w_active;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_extracted;

  // funct3[1:0] gives the size (00 byte, 01 half, 1x word); funct3[2] marks unsigned loads
  assign w_off      = exmem_alu_out[1:0];
  assign w_isByte   = (exmem_funct3[1:0] == 2'b00);
  assign w_isHalf   = (exmem_funct3[1:0] == 2'b01);
  assign w_isWord   = exmem_funct3[1];
  assign w_unsigned = exmem_funct3[2];

  // A read+write combination is treated as a load, so the store is dropped
  assign w_isLoad  = exmem_mem_read;
  assign w_isStore = exmem_mem_write & ~exmem_mem_read;
  assign w_access  = exmem_valid & (exmem_mem_read | exmem_mem_write);

  assign mem_misaligned = w_access &
                          ((w_isHalf & w_off[0]) | (w_isWord & (w_off != 2'b00)));
  assign w_op     = w_access & ~mem_misaligned;
  assign w_active = w_op & (r_state != DONE);

  assign data_read  = w_active & w_isLoad;
  assign data_write = w_active & w_isStore;
  assign mem_stall  = w_active;
  assign data_addr  = {exmem_alu_out[31:2], 2'b00};

  // Byte enables and lane-replicated store data; loads always fetch the whole word
  always_comb begin
    data_mbe   = 4'b1111;
    data_wdata = exmem_rs2_out;
    if (w_isStore) begin
      if (w_isByte) begin
        data_mbe   = 4'b0001 << w_off;
        data_wdata = {4{exmem_rs2_out[7:0]}};
      end else if (w_isHalf) begin
        data_mbe   = 4'b0011 << w_off;
        data_wdata = {2{exmem_rs2_out[15:0]}};
      end
    end
  end

  // State register; reset abandons any outstanding cache transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: wait for the cache response, then hold DONE until the pipeline advances
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_op) begin
          w_nextState = data_resp ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (data_resp) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (pipeline_load) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Capture the load word on the response; responses seen in DONE are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdataQ <= 32'h0;
    end else if (data_resp & w_active & w_isLoad) begin
      r_rdataQ <= data_rdata;
    end
  end

  // Pick the addressed byte/halfword from the captured word and extend it
  always_comb begin
    w_extracted = r_rdataQ;
    case (w_off)
      2'd0:    w_byte = r_rdataQ[7:0];
      2'd1:    w_byte = r_rdataQ[15:8];
      2'd2:    w_byte = r_rdataQ[23:16];
      default: w_byte = r_rdataQ[31:24];
    endcase
    w_half = w_off[1] ? r_rdataQ[31:16] : r_rdataQ[15:0];
    if (w_isByte) begin
      w_extracted = {{24{~w_unsigned & w_byte[7]}}, w_byte};
    end else if (w_isHalf) begin
      w_extracted = {{16{~w_unsigned & w_half[15]}}, w_half};
    end
  end

  assign mem_rdata = ((r_state == DONE) & w_op & w_isLoad) ? w_extracted : 32'h0;

endmodule
